// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: reset vector default, NOP encoding and
// the fetch-stage state encoding.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, instruction memory request and the
// IF/ID slot feeding the decoder.
// Optional build macro INSTR_FETCH_DELAY_SLOT_EN: a redirect keeps the
// same-cycle (or next) fetched instruction as a branch delay slot instead of
// flushing it.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | slot empty or draining; requesting from instruction memory
// ST_HOLD | slot full and decode stalled; no request issued
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next, pc_plus4, redirect_tgt;
    logic         slot_held, accept, load_slot, clear_slot;

`ifdef INSTR_FETCH_DELAY_SLOT_EN
    logic         pend_valid, pend_valid_next;
    logic [31:0]  pend_pc, pend_pc_next;
`endif

    assign imem_addr    = pc;
    assign pc_plus4     = pc + 32'd4;
    // Targets are silently word-aligned; there is no misalignment trap.
    assign redirect_tgt = redirect_pc & ~32'h0000_0003;

    // Next-state, request and slot/PC control decisions.
    always_comb begin
        state_next = state;
        imem_req   = (state == ST_RUN);
        // A valid slot under stall cannot take a new word; a response that
        // arrives then is dropped and refetched because PC does not move.
        slot_held  = stall && if_valid;
        accept     = imem_req && imem_ready && !slot_held;
        load_slot  = 1'b0;
        clear_slot = 1'b0;
        pc_next    = pc;

        case (state)
            ST_RUN:  if (!redirect && slot_held) state_next = ST_HOLD;
            ST_HOLD: if (redirect || !stall)     state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase

`ifdef INSTR_FETCH_DELAY_SLOT_EN
        pend_valid_next = pend_valid;
        pend_pc_next    = pend_pc;
        if (accept) begin
            load_slot       = 1'b1;
            pend_valid_next = 1'b0;
            if (redirect)        pc_next = redirect_tgt;
            else if (pend_valid) pc_next = pend_pc;
            else                 pc_next = pc_plus4;
        end else begin
            if (!slot_held) clear_slot = 1'b1;
            // Newest redirect wins while waiting for the delay-slot fetch.
            if (redirect) begin
                pend_valid_next = 1'b1;
                pend_pc_next    = redirect_tgt;
            end
        end
`else
        if (redirect) begin
            clear_slot = 1'b1;
            pc_next    = redirect_tgt;
        end else if (accept) begin
            load_slot  = 1'b1;
            pc_next    = pc_plus4;
        end else if (!slot_held) begin
            clear_slot = 1'b1;
        end
`endif
    end

    // State, PC and IF/ID slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
            if_pc    <= 32'h0;
            if_pc4   <= 32'h0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (load_slot) begin
                if_valid <= 1'b1;
                if_instr <= imem_rdata;
                if_pc    <= pc;
                if_pc4   <= pc_plus4;
            end else if (clear_slot) begin
                if_valid <= 1'b0;
            end
        end
    end

`ifdef INSTR_FETCH_DELAY_SLOT_EN
    // Pending redirect target awaiting its delay-slot fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_pc    <= 32'h0;
        end else begin
            pend_valid <= pend_valid_next;
            pend_pc    <= pend_pc_next;
        end
    end
`endif

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-005 SHALL have port imem_addr  output  32  word-aligned fetch address; equals PC.
REQ-006 SHALL have port imem_ready  input  1  memory returns imem_rdata this cycle; a transfer occurs only when imem_req && imem_ready.
REQ-007 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port stall  input  1  decode stage cannot consume the IF/ID slot this cycle.
REQ-009 SHALL have port redirect  input  1  taken branch/jump; load PC from redirect_pc.
REQ-010 SHALL have port redirect_pc  input  32  branch/jump target.
REQ-011 SHALL have ports if_valid (1), if_instr (32), if_pc (32), if_pc4 (32), all outputs: IF/ID slot contents feeding the instruction decoder.

Function
REQ-012 SHALL implement states RUN (slot empty or draining, requesting) and HOLD (slot full and stall high, no request).
REQ-013 SHALL drive imem_req=1 in RUN, 0 in HOLD; imem_addr=PC combinationally.
REQ-014 SHALL, on a transfer in RUN with no redirect: load if_instr<=imem_rdata, if_pc<=PC, if_pc4<=PC+4, if_valid<=1, PC<=PC+4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0).
REQ-015 SHALL, when stall=0 and no transfer, clear if_valid next cycle (slot consumed, bubble).
REQ-016 SHALL, when stall=1 and if_valid=1, hold slot unchanged and enter HOLD; return to RUN the cycle after stall falls.
REQ-017 SHALL, when stall=1 and if_valid=0, keep fetching and fill the slot (stall affects only a valid slot).
REQ-018 SHALL give redirect priority over stall and over any transfer: PC<={redirect_pc[31:2],2'b00} next cycle, state RUN.
REQ-019 SHALL force redirect_pc[1:0] to zero; no misalignment exception.
REQ-020 SHALL deliver a fetched instruction to if_instr with one-cycle latency after the transfer cycle; back-to-back transfers sustain one instruction per cycle.

Reset
REQ-021 SHALL, while rst_n=0, asynchronously set PC=RESET_PC, if_valid=0, if_instr=32'h0, if_pc=0, if_pc4=0, state RUN, pending redirect cleared.
REQ-022 SHALL assert imem_req in the first clock edge after rst_n rises; reset mid-transfer discards the response.

Configuration
REQ-023 SHALL use macro INSTR_FETCH_DELAY_SLOT_EN.
REQ-024 Without macro: redirect discards the same-cycle transfer and clears if_valid next cycle (flush).
REQ-025 With macro: the same-cycle transfer (or, if none, the next transfer) is kept as the delay slot; target stored in a pending-redirect register and PC loads it after that transfer; a second redirect while pending overwrites the target.

Structure
REQ-026 SHALL place RESET_PC default, NOP encoding 32'h0000_0000 and the RUN/HOLD state encoding in shared package cpu_pkg.
REQ-027 SHALL be a single module; no sub-module, PC+4 adder inline.

Verification
REQ-028 Reset release, imem_ready=1 always, stall=0 -> imem_addr 0,4,8; if_instr matches rdata one cycle later, if_pc4=if_pc+4.
REQ-029 Slot valid, stall=1 for 3 cycles -> imem_req=0, slot stable, PC unchanged; fetch resumes cycle after stall falls.
REQ-030 redirect=1, redirect_pc=32'h0000_0103 with transfer same cycle -> next imem_addr 32'h0000_0100; without macro if_valid=0, with macro that transfer appears in slot.
REQ-031 imem_ready low 4 cycles -> imem_req held, imem_addr stable, if_valid falls to 0 when stall=0.
REQ-032 PC=32'hFFFF_FFFC transfer -> next imem_addr 32'h0; rst_n pulsed low mid-stream -> outputs cleared immediately, PC=RESET_PC.
